fifo_pkt_wrapper_infill: RTL and testbench
==========================================

Name: fifo_pkt_wrapper_infill

Overview:
- Single-clock, show-ahead streaming packet FIFO for wide data beats (default 512 bits).
- Carries startofpacket, endofpacket and empty sideband alongside each beat.
- Exposes occupancy through a read-only CSR port; csr_readdata feeds the fill_level/almost_full logic of the unified FIFO wrapper.
- Sits between pipeline stages and provides elastic buffering with valid/ready backpressure.

Parameters:
- SYMBOLS_PER_BEAT, 64, symbols per data beat.
- BITS_PER_SYMBOL, 8, bits per symbol; data width DW = SYMBOLS_PER_BEAT*BITS_PER_SYMBOL.
- FIFO_DEPTH, 512, capacity in beats; power of two, >=4.
- USE_PACKETS, 1, 1 = store and forward startofpacket, endofpacket and empty; 0 = those outputs are tied to 0.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- csr_address  in  3  CSR register select.
- csr_read  in  1  CSR read strobe.
- csr_write  in  1  CSR write strobe (ignored).
- csr_readdata  out  32  CSR read data.
- csr_writedata  in  32  CSR write data (ignored).
- in_data  in  DW  input beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  FIFO can accept a beat.
- in_startofpacket  in  1  first beat of packet.
- in_endofpacket  in  1  last beat of packet.
- in_empty  in  6  unused symbols in the endofpacket beat.
- out_data  out  DW  head beat.
- out_valid  out  1  head beat valid.
- out_ready  in  1  consumer accepts the head beat.
- out_startofpacket  out  1  head beat sideband.
- out_endofpacket  out  1  head beat sideband.
- out_empty  out  6  head beat sideband.

Behaviour:
- Reset: while reset is high and on the first edge after it falls, all of the following are 0: pointers, count, out_valid, in_ready, csr_readdata, out sideband. Reset mid-operation discards all contents immediately.
- Push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated on the same clk edge.
- count = beats accepted and not yet popped, including any beat held in the output stage; range 0..FIFO_DEPTH; width $clog2(FIFO_DEPTH)+1.
- in_ready = (count < FIFO_DEPTH), decoded from the registered count. A full FIFO does not accept a beat even when a pop occurs in the same cycle.
- Storage is a simple dual-port RAM with synchronous read, plus a registered show-ahead output stage.
- Latency into an empty FIFO: beat pushed at edge N gives out_valid=1 with that beat after edge N+2. Steady-state throughput is one beat per cycle.
- out_* hold stable while out_valid=1 and out_ready=0.
- Order is strictly FIFO; sideband stays aligned with its beat. The FIFO does not check packet framing.
- Simultaneous push and pop: count is unchanged. Push only: count+1. Pop only: count-1.
- Pointers wrap modulo FIFO_DEPTH.
- in_valid while full: the beat is dropped and no state changes; upstream must honour in_ready.
- out_ready while empty: no effect; count never underflows.
- CSR reads are registered, latency 1: csr_readdata updates on every edge where csr_read=1, otherwise it holds its value.
- CSR map: address 0 = count, zero-extended to 32 bits; address 1 = FIFO_DEPTH; all other addresses = 0.
- csr_write and csr_writedata have no effect.

Optional Feature:
- Macro FIFO_TRACE_EN.
- When defined: a 32-bit cycle counter (reset to 0, +1 per clk) is compiled in, and simulation-only $display calls report:
  - every push: cycle, count;
  - every pop: cycle, count;
  - any in_valid while full, as "overflow".
- When undefined: no counter and no display logic; port behaviour is identical in both cases.

Decomposition:
- Package fifo_pkt_pkg holds:
  - EMPTY_WIDTH=6, CSR_ADDR_WIDTH=3, CSR_DATA_WIDTH=32;
  - CSR address constants CSR_FILL_LEVEL=0, CSR_DEPTH=1.
- One sub-module, fifo_pkt_ram: simple dual-port RAM with synchronous read, width DW+8 (data, sop, eop, empty), depth FIFO_DEPTH.

Test Plan:
- Reset, then push 1 beat (data=0xA5.., sop=1, eop=1, empty=5) at edge N -> out_valid=1 after edge N+2 with identical fields; csr addr 0 reads 1, then 0 after the pop.
- Push 512 beats with out_ready=0 -> in_ready=0 after the 512th push; count=512; a 513th in_valid is ignored; beats drain in order 0..511.
- Continuous push and pop with out_ready=1 -> one beat per cycle; count stays constant; no bubbles after fill.
- Random out_ready stalls over 1000 beats with 3-beat packets -> output data, sop, eop and empty match the input sequence exactly.
- Assert reset with count=100 -> out_valid=0 and count=0 immediately; the next push emerges after 2 cycles.
- USE_PACKETS=0 with sop=1, eop=1, empty=7 -> out sideband is all 0; data passes through unchanged.

Source files
------------

// File: rtl/fifo_pkt_pkg.sv
// Shared constants and sideband bundle for the streaming packet FIFO.
// Optional trace logic in the top is enabled by FIFO_TRACE_EN.
package fifo_pkt_pkg;
  localparam int EMPTY_WIDTH    = 6;
  localparam int CSR_ADDR_WIDTH = 3;
  localparam int CSR_DATA_WIDTH = 32;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_FILL_LEVEL = 3'd0;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_DEPTH      = 3'd1;

  typedef struct packed {
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
  } side_t;

  localparam int SIDE_WIDTH = $bits(side_t);
endpackage

// File: rtl/fifo_pkt_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// The read register holds its value while rd_en is low.
module fifo_pkt_ram #(
  parameter int WIDTH = 520,
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fifo_pkt_wrapper_infill.sv
// Show-ahead packet FIFO: RAM, read stage and output register.
// Define FIFO_TRACE_EN to compile in cycle counter and trace prints.
module fifo_pkt_wrapper_infill
  import fifo_pkt_pkg::*;
#(
  parameter int SYMBOLS_PER_BEAT = 64,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int FIFO_DEPTH       = 512,
  parameter int USE_PACKETS      = 1,
  localparam int DW = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
  input  logic                      csr_read,
  input  logic                      csr_write,
  output logic [CSR_DATA_WIDTH-1:0] csr_readdata,
  input  logic [CSR_DATA_WIDTH-1:0] csr_writedata,
  input  logic [DW-1:0]             in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_startofpacket,
  input  logic                      in_endofpacket,
  input  logic [EMPTY_WIDTH-1:0]    in_empty,
  output logic [DW-1:0]             out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [EMPTY_WIDTH-1:0]    out_empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = DW + SIDE_WIDTH;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, ram_cnt;
  logic          ready_en, mid_valid;
  logic          push, pop, mid_move, rd_en;
  side_t         in_side, mid_side, out_side;
  logic [RW-1:0] wr_word, rd_word;
  logic [DW-1:0] out_q;
  logic          unused_csr;

  assign unused_csr = ^{csr_write, csr_writedata};

  always_comb begin
    in_side = '0;
    if (USE_PACKETS != 0) begin
      in_side.sop   = in_startofpacket;
      in_side.eop   = in_endofpacket;
      in_side.empty = in_empty;
    end
  end

  assign in_ready = ready_en & (count < CW'(FIFO_DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Beats still in RAM, i.e. not yet in the read or output stage.
  assign ram_cnt  = count - CW'(mid_valid) - CW'(out_valid);
  assign mid_move = mid_valid & (~out_valid | out_ready);
  assign rd_en    = (ram_cnt != '0) & (~mid_valid | mid_move);

  assign wr_word  = {in_side, in_data};
  assign mid_side = side_t'(rd_word[RW-1:DW]);

  fifo_pkt_ram #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready_en  <= 1'b0;
      mid_valid <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_side  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      mid_valid <= rd_en | (mid_valid & ~mid_move);
      out_valid <= mid_move | (out_valid & ~out_ready);
      if (mid_move) begin
        out_q    <= rd_word[DW-1:0];
        out_side <= mid_side;
      end
    end
  end

  assign out_data          = out_q;
  assign out_startofpacket = (USE_PACKETS != 0) & out_side.sop;
  assign out_endofpacket   = (USE_PACKETS != 0) & out_side.eop;
  assign out_empty = (USE_PACKETS != 0) ? out_side.empty : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_readdata <= '0;
    end else if (csr_read) begin
      case (csr_address)
        CSR_FILL_LEVEL: csr_readdata <= CSR_DATA_WIDTH'(count);
        CSR_DEPTH:      csr_readdata <= CSR_DATA_WIDTH'(FIFO_DEPTH);
        default:        csr_readdata <= '0;
      endcase
    end
  end

`ifdef FIFO_TRACE_EN
  logic [31:0] cycle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle <= '0;
    else       cycle <= cycle + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push) $display("push cycle=%0d count=%0d", cycle, count);
      if (pop)  $display("pop cycle=%0d count=%0d", cycle, count);
      if (in_valid && !in_ready && ready_en)
        $display("overflow cycle=%0d count=%0d", cycle, count);
    end
  end
`endif
endmodule

// File: tb/tb_fifo_pkt_wrapper_infill.sv
// Directed bench for fifo_pkt_wrapper_infill (default and no-packet builds).
// All expected values are computed here from the stimulus.
module tb_fifo_pkt_wrapper_infill;
  localparam int DW = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]    csr_address;
  logic          csr_read, csr_write;
  logic [31:0]   csr_readdata, csr_writedata;
  logic [DW-1:0] in_data, out_data;
  logic          in_valid, in_ready, in_sop, in_eop;
  logic [5:0]    in_empty, out_empty;
  logic          out_valid, out_ready, out_sop, out_eop;

  logic [2:0]    b_csr_address;
  logic          b_csr_read;
  logic [31:0]   b_csr_readdata;
  logic [DW-1:0] b_in_data, b_out_data;
  logic          b_in_valid, b_in_ready, b_in_sop, b_in_eop;
  logic [5:0]    b_in_empty, b_out_empty;
  logic          b_out_valid, b_out_ready, b_out_sop, b_out_eop;

  fifo_pkt_wrapper_infill u_dut (
    .clk               (clk),
    .reset             (reset),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_readdata      (csr_readdata),
    .csr_writedata     (csr_writedata),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .in_empty          (in_empty),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_empty         (out_empty)
  );

  fifo_pkt_wrapper_infill #(
    .FIFO_DEPTH  (4),
    .USE_PACKETS (0)
  ) u_nopkt (
    .clk               (clk),
    .reset             (reset),
    .csr_address       (b_csr_address),
    .csr_read          (b_csr_read),
    .csr_write         (1'b0),
    .csr_readdata      (b_csr_readdata),
    .csr_writedata     (32'h0),
    .in_data           (b_in_data),
    .in_valid          (b_in_valid),
    .in_ready          (b_in_ready),
    .in_startofpacket  (b_in_sop),
    .in_endofpacket    (b_in_eop),
    .in_empty          (b_in_empty),
    .out_data          (b_out_data),
    .out_valid         (b_out_valid),
    .out_ready         (b_out_ready),
    .out_startofpacket (b_out_sop),
    .out_endofpacket   (b_out_eop),
    .out_empty         (b_out_empty)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [5:0]    e;
  } beat_t;

  beat_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input int i);
    logic [31:0] v;
    v = i;
    return {16{v}};
  endfunction

  task automatic csr_rd(input logic [2:0] a, input logic [31:0] exp,
                        input string tag);
    csr_address = a;
    csr_read = 1'b1;
    step();
    csr_read = 1'b0;
    check(tag, csr_readdata, exp);
  endtask

  task automatic b_csr_rd(input logic [2:0] a, input logic [31:0] exp,
                          input string tag);
    b_csr_address = a;
    b_csr_read = 1'b1;
    step();
    b_csr_read = 1'b0;
    check(tag, b_csr_readdata, exp);
  endtask

  initial begin
    int k, bub, sent, rcvd;
    beat_t bt, nb;
    logic [31:0] r;
    reset = 1'b1;
    csr_address = '0; csr_read = 0; csr_write = 0; csr_writedata = '0;
    in_data = '0; in_valid = 0; in_sop = 0; in_eop = 0; in_empty = '0;
    out_ready = 0;
    b_csr_address = '0; b_csr_read = 0;
    b_in_data = '0; b_in_valid = 0; b_in_sop = 0; b_in_eop = 0;
    b_in_empty = '0; b_out_ready = 0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_csr", csr_readdata, 0);
    check("rst_side", {out_sop, out_eop, out_empty}, 0);
    reset = 1'b0;
    check("rst_rdy_pre", in_ready, 0);
    step();
    check("rst_rdy_post", in_ready, 1);
    check("rst_ov_post", out_valid, 0);

    // single beat latency
    in_valid = 1; in_data = {64{8'hA5}};
    in_sop = 1; in_eop = 1; in_empty = 6'd5;
    step();
    in_valid = 0; in_sop = 0; in_eop = 0; in_empty = 0;
    check("lat_n", out_valid, 0);
    step();
    check("lat_n1", out_valid, 0);
    step();
    check("lat_n2", out_valid, 1);
    check("one_data", out_data, {64{8'hA5}});
    check("one_sop", out_sop, 1);
    check("one_eop", out_eop, 1);
    check("one_empty", out_empty, 5);
    csr_rd(3'd0, 32'd1, "csr_cnt1");
    check("hold_data", out_data, {64{8'hA5}});
    check("hold_valid", out_valid, 1);
    out_ready = 1;
    step();
    out_ready = 0;
    check("pop_valid", out_valid, 0);
    csr_rd(3'd0, 32'd0, "csr_cnt0");
    csr_write = 1; csr_writedata = '1;
    csr_rd(3'd1, 32'd512, "csr_depth");
    csr_write = 0; csr_writedata = '0;
    csr_rd(3'd5, 32'd0, "csr_other");
    csr_rd(3'd0, 32'd0, "csr_wr_ign");

    // fill to capacity
    for (int i = 0; i < 512; i++) begin
      in_valid = 1; in_data = mk(i);
      step();
    end
    check("full_rdy", in_ready, 0);
    in_data = mk(999);
    step();
    in_valid = 0;
    check("full_rdy2", in_ready, 0);
    csr_rd(3'd0, 32'd512, "full_cnt");
    out_ready = 1; k = 0; bub = 0;
    for (int c = 0; c < 2000 && k < 512; c++) begin
      if (out_valid) begin
        check("drain_data", out_data, mk(k));
        k++;
      end else bub++;
      step();
    end
    out_ready = 0;
    check("drain_n", k, 512);
    check("drain_bubbles", bub, 0);
    repeat (3) step();
    check("no_overflow_beat", out_valid, 0);
    csr_rd(3'd0, 32'd0, "drain_cnt");

    // continuous streaming
    out_ready = 1; k = 0;
    for (int i = 0; i < 60; i++) begin
      if (i >= 3) begin
        check("ss_valid", out_valid, 1);
        check("ss_data", out_data, mk(1000 + k));
        k++;
      end
      in_valid = 1; in_data = mk(1000 + i);
      csr_address = 0; csr_read = 1;
      step();
      if (i >= 3) check("ss_cnt", csr_readdata, 3);
    end
    in_valid = 0; csr_read = 0;
    for (int c = 0; c < 20 && k < 60; c++) begin
      if (out_valid) begin
        check("ss_tail", out_data, mk(1000 + k));
        k++;
      end
      step();
    end
    out_ready = 0;
    check("ss_n", k, 60);
    csr_rd(3'd0, 32'd0, "ss_end_cnt");

    // random stalls with 3-beat packets
    sent = 0; rcvd = 0;
    for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
      r = $urandom;
      nb.d = {16{r}};
      nb.sop = (sent % 3) == 0;
      nb.eop = (sent % 3) == 2;
      nb.e = nb.eop ? 6'((sent * 5) % 64) : 6'd0;
      in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data = nb.d; in_sop = nb.sop; in_eop = nb.eop; in_empty = nb.e;
      out_ready = $urandom_range(0, 2) != 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rnd_underflow", 1, 0);
        end else begin
          bt = q.pop_front();
          check("rnd_data", out_data, bt.d);
          check("rnd_sop", out_sop, bt.sop);
          check("rnd_eop", out_eop, bt.eop);
          check("rnd_empty", out_empty, bt.e);
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        q.push_back(nb);
        sent++;
      end
      step();
    end
    in_valid = 0; out_ready = 0;
    in_sop = 0; in_eop = 0; in_empty = 0;
    check("rnd_n", rcvd, 1000);
    csr_rd(3'd0, 32'd0, "rnd_cnt");

    // reset while holding 100 beats
    for (int i = 0; i < 100; i++) begin
      in_valid = 1; in_data = mk(7000 + i);
      step();
    end
    in_valid = 0;
    csr_rd(3'd0, 32'd100, "pre_rst_cnt");
    #2 reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 0);
    check("arst_csr", csr_readdata, 0);
    step();
    reset = 1'b0;
    step();
    csr_rd(3'd0, 32'd0, "arst_cnt");
    in_valid = 1; in_data = mk(8888);
    step();
    in_valid = 0;
    step();
    check("arst_lat1", out_valid, 0);
    step();
    check("arst_lat2", out_valid, 1);
    check("arst_data", out_data, mk(8888));
    out_ready = 1;
    step();
    out_ready = 0;

    // no-packet build: sideband forced low, data intact
    b_in_valid = 1; b_in_data = mk(32'h1234);
    b_in_sop = 1; b_in_eop = 1; b_in_empty = 6'd7;
    step();
    b_in_sop = 0; b_in_eop = 0; b_in_empty = 0;
    b_in_valid = 0;
    step();
    check("np_lat1", b_out_valid, 0);
    step();
    check("np_valid", b_out_valid, 1);
    check("np_data", b_out_data, mk(32'h1234));
    check("np_side", {b_out_sop, b_out_eop, b_out_empty}, 0);
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1; b_in_data = mk(i);
      b_in_sop = 1; b_in_eop = 1; b_in_empty = 6'd7;
      step();
    end
    b_in_valid = 0;
    check("np_full", b_in_ready, 0);
    b_csr_rd(3'd0, 32'd4, "np_cnt");
    b_csr_rd(3'd1, 32'd4, "np_depth");
    b_out_ready = 1; k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      if (b_out_valid) begin
        check("np_order", b_out_data, (k == 0) ? mk(32'h1234) : mk(k - 1));
        check("np_side2", {b_out_sop, b_out_eop, b_out_empty}, 0);
        k++;
      end
      step();
    end
    b_out_ready = 0;
    check("np_n", k, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
